// File: rtl/fx2_slavefifo_responder.sv
// -----------------------------------------------------------------------------
// fx2_slavefifo_responder
//
// Behavioural-but-synthesizable stand-in for the Cypress FX2 side of the
// slave-FIFO bus. The FPGA capture interface drives the usual active-low
// strobes; this block answers with flaga/flagb and the fd bus exactly as the
// FX2 would. Two internal FIFOs hold the endpoint data:
//   EP6 (OUT, host -> FPGA): 8-bit FWFT FIFO, filled from the host byte port,
//                            drained by slrd.
//   EP2 (IN,  FPGA -> host): 9-bit {last, data} FIFO, filled by slwr,
//                            drained by the host byte port.
//
// Valid/ready: the host EP2 read port follows strict valid/ready semantics.
// host_rd_valid is high whenever EP2 holds a byte and host_rd_data /
// host_rd_last then describe the head entry; the byte is consumed on a rising
// edge where host_rd_valid and host_rd_ready are both high. host_rd_valid
// never drops without a consume, and host_rd_data is stable while waiting.
//
// Ports
//   clk, reset_i          single clock (== ifclk), async active-high reset
//   sloe, slrd, slwr      active-low FX2 strobes: fd drive, EP6 pop, EP2 push
//   fifoadr1/0            endpoint select: 00 = EP2, 10 = EP6, else none
//   pktend                active-low EP2 packet commit
//   flaga, flagb          EP2 full (active-low), EP6 empty (active-low)
//   fd                    bidirectional data bus
//   host_wr_*             host push into EP6 (host_wr_full = EP6 full)
//   host_rd_*             host valid/ready pop from EP2
//   zlp_count             saturating count of zero-length packets
//   err, err_clr          sticky protocol errors and their clear
// -----------------------------------------------------------------------------
module fx2_slavefifo_responder #(
    parameter int DEPTH_LOG2 = 9,
    parameter int PKT_SIZE   = 512
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       sloe,
    input  logic       slrd,
    input  logic       slwr,
    input  logic       fifoadr0,
    input  logic       fifoadr1,
    input  logic       pktend,
    output logic       flaga,
    output logic       flagb,
    inout  wire  [7:0] fd,
    input  logic [7:0] host_wr_data,
    input  logic       host_wr_en,
    output logic       host_wr_full,
    output logic [7:0] host_rd_data,
    output logic       host_rd_last,
    output logic       host_rd_valid,
    input  logic       host_rd_ready,
    output logic [7:0] zlp_count,
    output logic [3:0] err,
    input  logic       err_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PKT_LAST = PTR_W'(PKT_SIZE);

    // Pointers carry one wrap bit above the index: equal pointers mean empty,
    // equal indices with differing wrap bits mean full.
    function automatic logic ptr_full(input logic [PTR_W-1:0] w,
                                      input logic [PTR_W-1:0] r);
        return (w[DEPTH_LOG2] != r[DEPTH_LOG2]) &&
               (w[DEPTH_LOG2-1:0] == r[DEPTH_LOG2-1:0]);
    endfunction

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0] ep6_mem [DEPTH];
    logic [8:0] ep2_mem [DEPTH];

    logic [PTR_W-1:0] ep6_wr_q, ep6_wr_d;
    logic [PTR_W-1:0] ep6_rd_q, ep6_rd_d;
    logic [PTR_W-1:0] ep2_wr_q, ep2_wr_d;
    logic [PTR_W-1:0] ep2_rd_q, ep2_rd_d;
    logic             ep6_empty_q, ep6_empty_d;
    logic             ep6_full_q,  ep6_full_d;
    logic             ep2_empty_q, ep2_empty_d;
    logic             ep2_full_q,  ep2_full_d;
    logic [PTR_W-1:0] pcnt_q, pcnt_d;
    logic [7:0]       zlp_q, zlp_d;
    logic [3:0]       err_q, err_d;

    // ------------------------------------------------------------------
    // Strobe decode
    // ------------------------------------------------------------------
    logic addr_ep2, addr_ep6;
    logic conflict, rd6_req, wr2_req, commit_req;
    logic ep6_push, ep6_pop, ep2_push, ep2_pop;
    logic underrun, overrun, wr_while_oe;
    logic [PTR_W-1:0] pcnt_inc;
    logic push_last, tail_fix;
    logic [DEPTH_LOG2-1:0] ep2_tail_idx;

    always_comb begin
        addr_ep2 = ({fifoadr1, fifoadr0} == 2'b00);
        addr_ep6 = ({fifoadr1, fifoadr0} == 2'b10);

        // slrd and slwr together on a real endpoint cancel each other.
        conflict = ~slrd & ~slwr & (addr_ep2 | addr_ep6);
        rd6_req  = ~slrd &  slwr & addr_ep6;
        wr2_req  = ~slwr &  slrd & addr_ep2;
        commit_req = ~pktend & addr_ep2;

        ep6_push = host_wr_en & ~ep6_full_q;
        ep6_pop  = rd6_req & ~ep6_empty_q;
        ep2_push = wr2_req & ~ep2_full_q;
        ep2_pop  = ~ep2_empty_q & host_rd_ready;

        underrun    = rd6_req & ep6_empty_q;
        overrun     = wr2_req & ep2_full_q;
        wr_while_oe = wr2_req & ~sloe;

        pcnt_inc  = pcnt_q + PTR_ONE;
        push_last = commit_req | (pcnt_inc == PKT_LAST);

        // pktend without a same-cycle byte marks the newest entry as last.
        // If the host pops that entry on this very edge it is already outside
        // the FIFO, so the write lands in a dead slot and the commit is lost.
        tail_fix     = commit_req & ~ep2_push & (pcnt_q != '0);
        ep2_tail_idx = ep2_wr_q[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        ep6_wr_d = ep6_push ? ep6_wr_q + PTR_ONE : ep6_wr_q;
        ep6_rd_d = ep6_pop  ? ep6_rd_q + PTR_ONE : ep6_rd_q;
        ep2_wr_d = ep2_push ? ep2_wr_q + PTR_ONE : ep2_wr_q;
        ep2_rd_d = ep2_pop  ? ep2_rd_q + PTR_ONE : ep2_rd_q;

        ep6_empty_d = (ep6_wr_d == ep6_rd_d);
        ep6_full_d  = ptr_full(ep6_wr_d, ep6_rd_d);
        ep2_empty_d = (ep2_wr_d == ep2_rd_d);
        ep2_full_d  = ptr_full(ep2_wr_d, ep2_rd_d);

        pcnt_d = pcnt_q;
        if (ep2_push) begin
            pcnt_d = push_last ? '0 : pcnt_inc;
        end else if (commit_req && (pcnt_q != '0)) begin
            pcnt_d = '0;
        end

        zlp_d = zlp_q;
        if (commit_req && !ep2_push && (pcnt_q == '0) && (zlp_q != 8'hFF)) begin
            zlp_d = zlp_q + 8'd1;
        end

        // New errors win over a same-cycle clear.
        err_d = err_clr ? 4'b0000 : err_q;
        err_d = err_d | {wr_while_oe, conflict, overrun, underrun};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            ep6_wr_q    <= '0;
            ep6_rd_q    <= '0;
            ep2_wr_q    <= '0;
            ep2_rd_q    <= '0;
            ep6_empty_q <= 1'b1;
            ep6_full_q  <= 1'b0;
            ep2_empty_q <= 1'b1;
            ep2_full_q  <= 1'b0;
            pcnt_q      <= '0;
            zlp_q       <= '0;
            err_q       <= '0;
        end else begin
            ep6_wr_q    <= ep6_wr_d;
            ep6_rd_q    <= ep6_rd_d;
            ep2_wr_q    <= ep2_wr_d;
            ep2_rd_q    <= ep2_rd_d;
            ep6_empty_q <= ep6_empty_d;
            ep6_full_q  <= ep6_full_d;
            ep2_empty_q <= ep2_empty_d;
            ep2_full_q  <= ep2_full_d;
            pcnt_q      <= pcnt_d;
            zlp_q       <= zlp_d;
            err_q       <= err_d;
        end
    end

    // Array contents need no reset: the pointers define what is live.
    always_ff @(posedge clk) begin
        if (ep6_push) begin
            ep6_mem[ep6_wr_q[DEPTH_LOG2-1:0]] <= host_wr_data;
        end
        if (ep2_push) begin
            ep2_mem[ep2_wr_q[DEPTH_LOG2-1:0]] <= {push_last, fd};
        end else if (tail_fix) begin
            ep2_mem[ep2_tail_idx][8] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [7:0] ep6_head;
    logic [8:0] ep2_head;

    always_comb begin
        ep6_head = ep6_empty_q ? 8'h00 : ep6_mem[ep6_rd_q[DEPTH_LOG2-1:0]];
        ep2_head = ep2_empty_q ? 9'h000 : ep2_mem[ep2_rd_q[DEPTH_LOG2-1:0]];
    end

    assign fd = sloe ? 8'hzz : ep6_head;

    assign flaga         = ~ep2_full_q;
    assign flagb         = ~ep6_empty_q;
    assign host_wr_full  = ep6_full_q;
    assign host_rd_valid = ~ep2_empty_q;
    assign host_rd_data  = ep2_head[7:0];
    assign host_rd_last  = ep2_head[8];
    assign zlp_count     = zlp_q;
    assign err           = err_q;

endmodule

// File: tb/tb_fx2_slavefifo_responder.sv
module tb_fx2_slavefifo_responder;

  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int PKT   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic       sloe, slrd, slwr, fifoadr0, fifoadr1, pktend;
  logic       flaga, flagb;
  wire  [7:0] fd;
  logic [7:0] drv;
  logic       drv_en;
  logic [7:0] host_wr_data;
  logic       host_wr_en, host_wr_full;
  logic [7:0] host_rd_data;
  logic       host_rd_last, host_rd_valid, host_rd_ready;
  logic [7:0] zlp_count;
  logic [3:0] err;
  logic       err_clr;

  assign fd = drv_en ? drv : 8'hzz;

  fx2_slavefifo_responder #(.DEPTH_LOG2(DL2), .PKT_SIZE(PKT)) dut (
    .clk(clk), .reset_i(reset_i), .sloe(sloe), .slrd(slrd), .slwr(slwr),
    .fifoadr0(fifoadr0), .fifoadr1(fifoadr1), .pktend(pktend),
    .flaga(flaga), .flagb(flagb), .fd(fd),
    .host_wr_data(host_wr_data), .host_wr_en(host_wr_en), .host_wr_full(host_wr_full),
    .host_rd_data(host_rd_data), .host_rd_last(host_rd_last),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .zlp_count(zlp_count), .err(err), .err_clr(err_clr)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic       flaga;
    logic       flagb;
    logic       wr_full;
    logic       rd_valid;
    logic [3:0] err;
    logic [7:0] zlp;
    logic       chk_fd;
    logic [7:0] fd;
    logic       pop;
    logic [8:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: endpoint contents as plain queues.
  logic [7:0] m6[$];
  logic [8:0] m2[$];
  int         m_pcnt;
  int         m_zlp;
  logic [3:0] m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    m6.delete();
    m2.delete();
    m_pcnt = 0;
    m_zlp  = 0;
    m_err  = 4'b0000;
  endtask

  task automatic set_idle();
    sloe = 1'b1; slrd = 1'b1; slwr = 1'b1; pktend = 1'b1;
    {fifoadr1, fifoadr0} = 2'b11;
    host_wr_en = 1'b0; host_wr_data = 8'h00;
    host_rd_ready = 1'b0; err_clr = 1'b0;
    drv = 8'h00; drv_en = 1'b1;
  endtask

  task automatic set_addr(input logic [1:0] a);
    {fifoadr1, fifoadr0} = a;
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_cyc();
    @(negedge clk);
    #1;
    set_idle();
  endtask

  // Records expectations for the upcoming edge, then advances the model.
  task automatic commit();
    exp_t e;
    logic [7:0] wd;
    logic [8:0] t;
    bit ep2a, ep6a, conf, rd6, wr2, cmt, pop2, push2, pop6, push6, last;
    drv_en     = sloe;
    e.flaga    = (m2.size() != DEPTH);
    e.flagb    = (m6.size() != 0);
    e.wr_full  = (m6.size() == DEPTH);
    e.rd_valid = (m2.size() != 0);
    e.err      = m_err;
    e.zlp      = 8'(m_zlp);
    e.chk_fd   = !sloe;
    e.fd       = (m6.size() != 0) ? m6[0] : 8'h00;
    pop2       = (m2.size() != 0) && host_rd_ready;
    e.pop      = pop2;
    e.rd       = pop2 ? m2[0] : 9'h000;
    exp_q.push_back(e);

    ep2a = ({fifoadr1, fifoadr0} == 2'b00);
    ep6a = ({fifoadr1, fifoadr0} == 2'b10);
    conf = !slrd && !slwr && (ep2a || ep6a);
    rd6  = !slrd && slwr && ep6a;
    wr2  = !slwr && slrd && ep2a;
    cmt  = !pktend && ep2a;
    wd   = sloe ? drv : e.fd;

    if (err_clr) m_err = 4'b0000;
    if (rd6 && m6.size() == 0) m_err[0] = 1'b1;
    if (wr2 && m2.size() == DEPTH) m_err[1] = 1'b1;
    if (conf) m_err[2] = 1'b1;
    if (wr2 && !sloe) m_err[3] = 1'b1;

    push6 = host_wr_en && (m6.size() != DEPTH);
    pop6  = rd6 && (m6.size() != 0);
    push2 = wr2 && (m2.size() != DEPTH);

    if (pop6) void'(m6.pop_front());
    if (push6) m6.push_back(host_wr_data);
    if (pop2) void'(m2.pop_front());
    if (push2) begin
      m_pcnt++;
      last = cmt || (m_pcnt == PKT);
      if (last) m_pcnt = 0;
      m2.push_back({last, wd});
    end else if (cmt) begin
      if (m_pcnt > 0) begin
        // Newest write gets the last flag, if it is still in the FIFO.
        if (m2.size() > 0) begin
          t = m2[m2.size()-1];
          t[8] = 1'b1;
          m2[m2.size()-1] = t;
        end
        m_pcnt = 0;
      end else if (m_zlp < 255) begin
        m_zlp++;
      end
    end
  endtask

  task automatic idle_cyc();
    begin_cyc();
    commit();
    #1;
  endtask

  task automatic wr2b(input logic [7:0] b, input bit pe);
    begin_cyc();
    set_addr(2'b00);
    slwr = 1'b0;
    drv = b;
    pktend = !pe;
    commit();
  endtask

  task automatic rd2(input logic [7:0] ed, input bit el, input string nm);
    begin_cyc();
    host_rd_ready = 1'b1;
    commit();
    #1;
    check({nm, "_valid"}, 32'(host_rd_valid), 32'd1);
    check({nm, "_data"}, 32'(host_rd_data), 32'(ed));
    check({nm, "_last"}, 32'(host_rd_last), 32'(el));
  endtask

  task automatic pktend_cyc();
    begin_cyc();
    set_addr(2'b00);
    pktend = 1'b0;
    commit();
  endtask

  // Async reset raised away from any edge; outputs must react immediately.
  task automatic reset_check(input string tag);
    @(posedge clk);
    #2;
    set_idle();
    drv = 8'h5A;
    reset_i = 1'b1;
    #1;
    check({tag, "_flaga"}, 32'(flaga), 32'd1);
    check({tag, "_flagb"}, 32'(flagb), 32'd0);
    check({tag, "_wr_full"}, 32'(host_wr_full), 32'd0);
    check({tag, "_rd_valid"}, 32'(host_rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(host_rd_data), 32'd0);
    check({tag, "_rd_last"}, 32'(host_rd_last), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_zlp"}, 32'(zlp_count), 32'd0);
    check({tag, "_fd_released"}, 32'(fd), 32'h5A);
    sloe = 1'b0;
    drv_en = 1'b0;
    #1;
    check({tag, "_fd_empty"}, 32'(fd), 32'h00);
    sloe = 1'b1;
    drv_en = 1'b1;
    @(negedge clk);
    #1;
    reset_i = 1'b0;
    model_clear();
  endtask

  // ---------------- monitor ----------------
  exp_t me;
  always begin
    @(negedge clk);
    #4;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      check("mon_flaga", 32'(flaga), 32'(me.flaga));
      check("mon_flagb", 32'(flagb), 32'(me.flagb));
      check("mon_wr_full", 32'(host_wr_full), 32'(me.wr_full));
      check("mon_rd_valid", 32'(host_rd_valid), 32'(me.rd_valid));
      check("mon_err", 32'(err), 32'(me.err));
      check("mon_zlp", 32'(zlp_count), 32'(me.zlp));
      if (me.chk_fd) check("mon_fd", 32'(fd), 32'(me.fd));
      check("mon_pop", 32'(host_rd_valid && host_rd_ready), 32'(me.pop));
      if (me.pop) check("mon_rd_entry", 32'({host_rd_last, host_rd_data}), 32'(me.rd));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    model_clear();
    reset_check("reset");

    // EP6 read path
    begin_cyc(); host_wr_en = 1'b1; host_wr_data = 8'hA5; commit();
    begin_cyc(); host_wr_en = 1'b1; host_wr_data = 8'h3C; commit();
    begin_cyc(); sloe = 1'b0; set_addr(2'b10); slrd = 1'b0; commit(); #1;
    check("ep6_fd0", 32'(fd), 32'hA5);
    check("ep6_flagb_full", 32'(flagb), 32'd1);
    begin_cyc(); sloe = 1'b0; set_addr(2'b10); slrd = 1'b0; commit(); #1;
    check("ep6_fd1", 32'(fd), 32'h3C);
    idle_cyc();
    check("ep6_flagb_drained", 32'(flagb), 32'd0);
    check("ep6_err", 32'(err), 32'd0);

    // EP2 write with pktend
    wr2b(8'h11, 0); wr2b(8'h22, 0); wr2b(8'h33, 0);
    pktend_cyc();
    rd2(8'h11, 0, "pk_b0"); rd2(8'h22, 0, "pk_b1"); rd2(8'h33, 1, "pk_b2");

    // Automatic commit at PKT bytes, then pktend on a partial packet
    wr2b(8'h01, 0); wr2b(8'h02, 0); wr2b(8'h03, 0); wr2b(8'h04, 0);
    rd2(8'h01, 0, "ac_b1"); rd2(8'h02, 0, "ac_b2"); rd2(8'h03, 0, "ac_b3"); rd2(8'h04, 1, "ac_b4");
    wr2b(8'h05, 0); wr2b(8'h06, 0);
    pktend_cyc();
    rd2(8'h05, 0, "ac_b5"); rd2(8'h06, 1, "ac_b6");
    pktend_cyc();
    idle_cyc();
    check("zlp_one", 32'(zlp_count), 32'd1);

    // Commit dropped when the newest byte leaves in the same cycle
    wr2b(8'h07, 0);
    begin_cyc(); set_addr(2'b00); pktend = 1'b0; host_rd_ready = 1'b1; commit(); #1;
    check("drop_data", 32'(host_rd_data), 32'h07);
    idle_cyc();
    check("drop_zlp", 32'(zlp_count), 32'd1);
    check("drop_empty", 32'(host_rd_valid), 32'd0);

    // Overflow on EP2, underrun on EP6, error clear
    wr2b(8'h10, 0); wr2b(8'h11, 0); wr2b(8'h12, 0); wr2b(8'h13, 0);
    wr2b(8'h14, 0); #1;
    check("ovf_flaga", 32'(flaga), 32'd0);
    idle_cyc();
    check("ovf_err", 32'(err), 32'b0010);
    rd2(8'h10, 0, "ovf_b0"); rd2(8'h11, 0, "ovf_b1"); rd2(8'h12, 0, "ovf_b2"); rd2(8'h13, 1, "ovf_b3");
    idle_cyc();
    check("ovf_dropped", 32'(host_rd_valid), 32'd0);
    begin_cyc(); set_addr(2'b10); slrd = 1'b0; commit();
    idle_cyc();
    check("udr_err", 32'(err), 32'b0011);
    begin_cyc(); err_clr = 1'b1; commit();
    idle_cyc();
    check("err_clr", 32'(err), 32'd0);

    // Simultaneous host push and slrd with one byte held
    begin_cyc(); host_wr_en = 1'b1; host_wr_data = 8'h77; commit();
    begin_cyc(); host_wr_en = 1'b1; host_wr_data = 8'h88;
    sloe = 1'b0; set_addr(2'b10); slrd = 1'b0; commit(); #1;
    check("cc_fd0", 32'(fd), 32'h77);
    idle_cyc();
    check("cc_flagb", 32'(flagb), 32'd1);
    begin_cyc(); sloe = 1'b0; set_addr(2'b10); slrd = 1'b0; commit(); #1;
    check("cc_fd1", 32'(fd), 32'h88);
    idle_cyc();
    check("cc_drained", 32'(flagb), 32'd0);

    // slrd+slwr together, then slwr while sloe is low
    begin_cyc(); set_addr(2'b00); slrd = 1'b0; slwr = 1'b0; drv = 8'h99; commit();
    idle_cyc();
    check("conf_err", 32'(err), 32'b0100);
    check("conf_no_push", 32'(host_rd_valid), 32'd0);
    begin_cyc(); sloe = 1'b0; set_addr(2'b00); slwr = 1'b0; commit();
    idle_cyc();
    check("oe_err", 32'(err), 32'b1100);
    rd2(8'h00, 0, "oe_byte");

    // Randomized traffic against the model, with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      int a;
      if (i == 700) reset_check("midreset");
      begin_cyc();
      sloe = ($urandom_range(0, 9) >= 3);
      a = $urandom_range(0, 9);
      set_addr(a < 4 ? 2'b00 : (a < 8 ? 2'b10 : (a == 8 ? 2'b01 : 2'b11)));
      slrd = ($urandom_range(0, 9) >= 4);
      slwr = ($urandom_range(0, 9) >= 4);
      pktend = ($urandom_range(0, 9) != 0);
      host_wr_en = 1'($urandom_range(0, 1));
      host_wr_data = 8'($urandom);
      host_rd_ready = 1'($urandom_range(0, 1));
      err_clr = ($urandom_range(0, 19) == 0);
      drv = 8'($urandom);
      commit();
    end

    // Drain EP2 through the host port (bounded)
    for (int i = 0; i < 2 * DEPTH; i++) begin
      begin_cyc(); host_rd_ready = 1'b1; commit();
    end
    idle_cyc();
    check("final_ep2_empty", 32'(host_rd_valid), 32'd0);
    @(negedge clk);
    #6;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
